ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_if.sv | 18 +
 rtl/ram_arbiter.sv | 92 +++++++++
 tb/tb_ram_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Requester-side handshake bundle for the two-port RAM arbiter.
// Per-requester fields are packed side by side: requester i owns slice i.
interface ram_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 8
);
    logic [1:0]      req;
    logic [1:0]      we;
    logic [2*AW-1:0] addr;
    logic [2*DW-1:0] wdata;
    logic [1:0]      gnt;
    logic [1:0]      rvalid;
    logic [DW-1:0]   rdata;
    logic            busy;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata, busy);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata, busy);
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two requesters.
// A write occupies one cycle; a read is followed by a TURN cycle that releases the data bus.
module ram_arbiter #(
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    ram_arbiter_if.slave  bus,
    output logic [AW-1:0] ram_addr,
    inout  wire  [DW-1:0] ram_data,
    output logic          ram_cs,
    output logic          ram_rd,
    output logic          ram_wr
);
    typedef enum logic [1:0] {IDLE, WR, RD, TURN} state_t;

    state_t        state, state_nxt;
    logic          last_owner, owner, winner, grant;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata, wdata_q;
    logic          drive;

    // Winner selection; a tie goes to whoever did not win last time.
    always_comb begin
        winner = 1'b0;
        unique case (bus.req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_owner;
            default: winner = 1'b0;
        endcase
        grant     = (state == IDLE) && (bus.req != 2'b00);
        win_we    = winner ? bus.we[1] : bus.we[0];
        win_addr  = winner ? bus.addr[2*AW-1:AW] : bus.addr[AW-1:0];
        win_wdata = winner ? bus.wdata[2*DW-1:DW] : bus.wdata[DW-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (grant) state_nxt = win_we ? WR : RD;
            WR:      state_nxt = IDLE;
            RD:      state_nxt = TURN;
            TURN:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ram_cs   = (state == WR) || (state == RD);
        ram_rd   = (state == RD);
        ram_wr   = (state == WR);
        bus.busy = (state != IDLE);
        drive    = (state == WR);
    end

    assign ram_data = drive ? wdata_q : {DW{1'bz}};

    // Command latch, grant/rvalid pulses and read capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.gnt    <= 2'b00;
            bus.rvalid <= 2'b00;
            bus.rdata  <= '0;
            ram_addr   <= '0;
            wdata_q    <= '0;
            owner      <= 1'b0;
            last_owner <= 1'b1;
        end else begin
            bus.gnt    <= 2'b00;
            bus.rvalid <= 2'b00;
            if (grant) begin
                bus.gnt[winner] <= 1'b1;
                owner           <= winner;
                last_owner      <= winner;
                ram_addr        <= win_addr;
                wdata_q         <= win_wdata;
            end
            if (state == RD) begin
                bus.rdata         <= ram_data;
                bus.rvalid[owner] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed and randomized bench for ram_arbiter against a per-transaction cycle-schedule model.
module tb_ram_arbiter;
    localparam int AW = 10;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_arbiter_if #(.AW(AW), .DW(DW)) bus();
    logic [AW-1:0] ram_addr;
    wire  [DW-1:0] ram_data;
    logic          ram_cs, ram_rd, ram_wr;

    ram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .ram_addr(ram_addr),
        .ram_data(ram_data), .ram_cs(ram_cs), .ram_rd(ram_rd), .ram_wr(ram_wr)
    );

    // Simple asynchronous-read RAM on the shared bus
    logic [DW-1:0] mem [1024] = '{default: 8'h00};
    assign ram_data = (ram_cs && ram_rd) ? mem[ram_addr] : {DW{1'bz}};
    always @(posedge clk) if (ram_cs && ram_wr) mem[ram_addr] <= ram_data;

    typedef struct {
        logic [1:0]    gnt, rvalid;
        logic          busy, cs, rd, wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] rdata;
        logic          chk_data;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] ref_mem [1024] = '{default: 8'h00};
    logic          last = 1'b1;
    logic          prev_idle = 1'b1;
    logic [AW-1:0] cur_addr = '0;
    logic [DW-1:0] cur_rdata = '0;

    logic          p_req [2] = '{1'b0, 1'b0};
    logic          p_we  [2] = '{1'b0, 1'b0};
    logic [AW-1:0] p_addr[2] = '{'0, '0};
    logic [DW-1:0] p_wd  [2] = '{'0, '0};
    logic          hold = 1'b0;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input string nm, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, nm, obs, exp_v);
        end
    endtask

    task automatic drive();
        bus.req   = {p_req[1], p_req[0]};
        bus.we    = {p_we[1], p_we[0]};
        bus.addr  = {p_addr[1], p_addr[0]};
        bus.wdata = {p_wd[1], p_wd[0]};
    endtask

    function automatic exp_t idle_e();
        exp_t e;
        e = '{gnt: 2'b00, rvalid: 2'b00, busy: 1'b0, cs: 1'b0, rd: 1'b0, wr: 1'b0,
              addr: cur_addr, rdata: cur_rdata, chk_data: 1'b0, data: '0};
        return e;
    endfunction

    // Schedule the cycles a granted command occupies: write = WR; read = RD then TURN.
    task automatic grant_cmd();
        exp_t    e;
        logic    w;
        logic [1:0] r;
        r = {p_req[1], p_req[0]};
        w = (r == 2'b11) ? ~last : r[1];
        last = w;
        cur_addr = p_addr[w];
        e = idle_e();
        e.gnt = 2'b01 << w;
        e.busy = 1'b1;
        e.cs = 1'b1;
        e.chk_data = 1'b1;
        if (p_we[w]) begin
            e.wr = 1'b1;
            e.data = p_wd[w];
            ref_mem[cur_addr] = p_wd[w];
            q.push_back(e);
        end else begin
            e.rd = 1'b1;
            e.data = ref_mem[cur_addr];
            q.push_back(e);
            cur_rdata = ref_mem[cur_addr];
            e = idle_e();
            e.busy = 1'b1;
            e.rvalid = 2'b01 << w;
            q.push_back(e);
        end
    endtask

    task automatic step(input string tag);
        exp_t e;
        drive();
        if (!rst_n) begin
            q.delete();
            last = 1'b1;
            cur_addr = '0;
            cur_rdata = '0;
            e = idle_e();
        end else begin
            if (q.size() == 0 && prev_idle && (p_req[0] || p_req[1])) grant_cmd();
            if (q.size() > 0) e = q.pop_front();
            else              e = idle_e();
        end
        prev_idle = !e.busy;
        @(posedge clk);
        #1;
        chk(tag, "gnt",      32'(bus.gnt),    32'(e.gnt));
        chk(tag, "rvalid",   32'(bus.rvalid), 32'(e.rvalid));
        chk(tag, "busy",     32'(bus.busy),   32'(e.busy));
        chk(tag, "ctl",      32'({ram_cs, ram_rd, ram_wr}), 32'({e.cs, e.rd, e.wr}));
        chk(tag, "ram_addr", 32'(ram_addr),   32'(e.addr));
        chk(tag, "rdata",    32'(bus.rdata),  32'(e.rdata));
        if (e.chk_data) chk(tag, "ram_data", 32'(ram_data), 32'(e.data));
        for (int i = 0; i < 2; i++) if (e.gnt[i] && !hold) p_req[i] = 1'b0;
    endtask

    task automatic set_cmd(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        p_req[i] = 1'b1; p_we[i] = w; p_addr[i] = a; p_wd[i] = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step("reset");
        step("reset");
        rst_n = 1'b1;
    endtask

    initial begin
        drive();
        do_reset();

        // single write from requester 0
        set_cmd(0, 1'b1, 10'h005, 8'hA5);
        step("wr0"); step("wr0"); step("wr0");

        // requester 1 writes then reads back the top address
        set_cmd(1, 1'b1, 10'h3FF, 8'h3C);
        step("wr1"); step("wr1");
        set_cmd(1, 1'b0, 10'h3FF, 8'h00);
        step("rd1"); step("rd1"); step("rd1"); step("rd1");

        // continuous contention, both reading
        do_reset();
        set_cmd(0, 1'b0, 10'h005, 8'h00);
        set_cmd(1, 1'b0, 10'h3FF, 8'h00);
        hold = 1'b1;
        for (int k = 0; k < 13; k++) step("cont");
        hold = 1'b0;
        p_req[0] = 1'b0; p_req[1] = 1'b0;
        step("cont"); step("cont"); step("cont");

        // read followed by a write to the same address
        do_reset();
        set_cmd(0, 1'b0, 10'h000, 8'h00);
        set_cmd(1, 1'b1, 10'h000, 8'hFF);
        for (int k = 0; k < 6; k++) step("turn");
        set_cmd(0, 1'b0, 10'h000, 8'h00);
        for (int k = 0; k < 4; k++) step("turn_rb");

        // reset while a read is in flight
        set_cmd(0, 1'b0, 10'h3FF, 8'h00);
        step("rst_rd");
        rst_n = 1'b0;
        step("rst_rd");
        rst_n = 1'b1;
        step("rst_rd"); step("rst_rd");

        // randomized traffic with occasional resets
        for (int k = 0; k < 500; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (!p_req[i] && $urandom_range(0, 2) == 0) begin
                    set_cmd(i, 1'($urandom_range(0, 1)),
                            ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 7)),
                            8'($urandom));
                end
            end
            rst_n = ($urandom_range(0, 59) != 0);
            step("rnd");
        end
        rst_n = 1'b1;
        p_req[0] = 1'b0; p_req[1] = 1'b0;
        step("drain"); step("drain"); step("drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
